// File: rtl/chip8_fb_pkg.sv
// Shared framebuffer geometry, row word type and draw FSM states for the Chip-8 display writer.
package chip8_fb_pkg;

  localparam int unsigned FB_ROWS = 32;
  localparam int unsigned FB_COLS = 64;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned ROW_W   = $clog2(FB_ROWS);
  localparam int unsigned COL_W   = $clog2(FB_COLS);
  localparam int unsigned N_W     = 4;
  localparam int unsigned BYTE_W  = 8;

  typedef logic [FB_COLS-1:0] fb_row_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } draw_state_e;

endpackage

// File: rtl/chip8_sprite_row_mask.sv
// Expands one sprite byte at column x0 into a framebuffer row mask.
// CHIP8_DRAW_WRAP_EN defined: columns past the right edge wrap to column 0; otherwise they are clipped.
module chip8_sprite_row_mask
  import chip8_fb_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  input  logic [COL_W-1:0]  x0_i,
  output fb_row_t           mask_o
);

`ifdef CHIP8_DRAW_WRAP_EN
  localparam int unsigned SUM_W = COL_W;
`else
  localparam int unsigned SUM_W = COL_W + 1;
`endif

  logic [SUM_W-1:0] col;

  // Sprite bit 7 lands on column x0, bit 0 on column x0+7.
  always_comb begin
    mask_o = '0;
    col    = '0;
    for (int k = 0; k < 8; k++) begin
      col = SUM_W'(x0_i) + SUM_W'(k);
`ifdef CHIP8_DRAW_WRAP_EN
      if (byte_i[3'(7 - k)]) begin
        mask_o[col[COL_W-1:0]] = 1'b1;
      end
`else
      if (byte_i[3'(7 - k)] && (col < SUM_W'(FB_COLS))) begin
        mask_o[col[COL_W-1:0]] = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/chip8_sprite_draw.sv
// Chip-8 framebuffer writer: DXYN sprite XOR-draw with collision flag, and 00E0 screen clear.
// CHIP8_DRAW_WRAP_EN defined: sprite rows/columns wrap around the screen edges;
// undefined: off-screen columns are clipped and off-screen rows are skipped.
module chip8_sprite_draw
  import chip8_fb_pkg::*;
(
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              draw_start,
  input  logic              clear_start,
  input  logic [7:0]        sprite_x,
  input  logic [7:0]        sprite_y,
  input  logic [N_W-1:0]    sprite_n,
  input  logic [ADDR_W-1:0] sprite_addr,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              fb_re,
  output logic              fb_we,
  output logic [ROW_W-1:0]  fb_addr,
  input  fb_row_t           fb_rdata,
  output fb_row_t           fb_wdata
);

  draw_state_e       state_q, state_d;
  logic [COL_W-1:0]  x0_q, x0_d;
  logic [ROW_W-1:0]  y0_q, y0_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [N_W-1:0]    r_q, r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              coll_q, coll_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fb_re_q, fb_re_d;
  logic              fb_we_q, fb_we_d;
  logic [ROW_W-1:0]  fb_addr_q, fb_addr_d;
  fb_row_t           fb_wdata_q, fb_wdata_d;

  fb_row_t           mask_c;
  logic [COL_W-1:0]  x_start_c;
  logic [ROW_W-1:0]  y_start_c;
  logic [N_W-1:0]    n_eff_c;
  logic [N_W-1:0]    r_next_c;
`ifndef CHIP8_DRAW_WRAP_EN
  logic [ROW_W:0]    rows_avail_c;
`endif

  // Mask for the byte arriving in WAIT, positioned at the latched start column.
  chip8_sprite_row_mask u_row_mask (
    .byte_i (mem_rdata),
    .x0_i   (x0_q),
    .mask_o (mask_c)
  );

  // Start coordinates always wrap; the row count is trimmed at the bottom edge when clipping.
  always_comb begin
    x_start_c = COL_W'(sprite_x);
    y_start_c = ROW_W'(sprite_y);
    n_eff_c   = sprite_n;
`ifndef CHIP8_DRAW_WRAP_EN
    rows_avail_c = (ROW_W+1)'(FB_ROWS) - (ROW_W+1)'(y_start_c);
    if ((ROW_W+1)'(sprite_n) > rows_avail_c) begin
      n_eff_c = N_W'(rows_avail_c);
    end
`endif
  end

  assign r_next_c = r_q + N_W'(1);

  // Next state and next registered outputs; strobes describe the state being entered.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    n_d        = n_q;
    i_d        = i_q;
    r_d        = r_q;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    coll_d     = coll_q;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    fb_re_d    = 1'b0;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (clear_start) begin
          state_d    = ST_CLEAR;
          busy_d     = 1'b1;
          coll_d     = 1'b0;
          r_d        = '0;
          fb_we_d    = 1'b1;
          fb_addr_d  = '0;
          fb_wdata_d = '0;
        end else if (draw_start) begin
          busy_d = 1'b1;
          coll_d = 1'b0;
          r_d    = '0;
          x0_d   = x_start_c;
          y0_d   = y_start_c;
          n_d    = n_eff_c;
          i_d    = sprite_addr;
          if (n_eff_c == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_FETCH;
            mem_re_d   = 1'b1;
            mem_addr_d = sprite_addr;
            fb_re_d    = 1'b1;
            fb_addr_d  = y_start_c;
          end
        end
      end
      ST_CLEAR: begin
        if (fb_addr_q == ROW_W'(FB_ROWS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          fb_we_d    = 1'b1;
          fb_addr_d  = fb_addr_q + ROW_W'(1);
          fb_wdata_d = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d    = ST_WRITE;
        fb_we_d    = 1'b1;
        fb_wdata_d = fb_rdata ^ mask_c;
        coll_d     = coll_q | (|(fb_rdata & mask_c));
      end
      ST_WRITE: begin
        r_d = r_next_c;
        if (r_next_c == n_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_FETCH;
          mem_re_d   = 1'b1;
          mem_addr_d = i_q + ADDR_W'(r_next_c);
          fb_re_d    = 1'b1;
          fb_addr_d  = y0_q + ROW_W'(r_next_c);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      n_q        <= '0;
      i_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      fb_re_q    <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      n_q        <= n_d;
      i_q        <= i_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      coll_q     <= coll_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      fb_re_q    <= fb_re_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = coll_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign fb_re     = fb_re_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;

endmodule
